reg_file_seq: RTL

- Parametrised register file for the multicycle core.
- Provides two combinational read ports and one write port.
- Includes a PC register with its own increment path.
- Includes a multi-register transfer sequencer for load-multiple / store-multiple instructions, which walks a register mask one register per cycle so the control FSM need not iterate.

---
 rtl/reg_file_seq.sv | 118 +++++++++++
 1 files changed

// File: rtl/reg_file_seq.sv
// Register file with combinational read ports, a PC increment path and a
// load/store-multiple sequencer. Define RF_BYPASS_EN to forward same-cycle writes.
module reg_file_seq #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3,
  parameter int PC_IDX   = 7
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   rd_addr1,
  input  logic [ADDR_W-1:0]   rd_addr2,
  output logic [DATA_W-1:0]   rd_data1,
  output logic [DATA_W-1:0]   rd_data2,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                pc_inc,
  output logic [DATA_W-1:0]   pc_out,
  input  logic                seq_start,
  input  logic                seq_mode,
  input  logic [NUM_REGS-1:0] seq_mask,
  input  logic [DATA_W-1:0]   seq_data_in,
  output logic                seq_busy,
  output logic                seq_valid,
  output logic [ADDR_W-1:0]   seq_addr,
  output logic [DATA_W-1:0]   seq_data_out,
  output logic                seq_done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e              state_q, state_d;
  logic                mode_q, mode_d;
  logic [NUM_REGS-1:0] mask_q, mask_d;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [DATA_W-1:0]   view   [NUM_REGS];
  logic [ADDR_W-1:0]   idx;
  logic                run;
  logic                seq_ld;
  logic                ext_we;

  assign run    = (state_q == RUN);
  assign seq_ld = run && mode_q;
  assign ext_we = wr_en && !seq_ld;

  always_comb begin
    idx = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (mask_q[i]) idx = ADDR_W'(i);
    end
  end

  // Later assignments win: writes override the PC increment.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) regs_d[i] = regs_q[i];
    if (pc_inc) regs_d[PC_IDX] = regs_q[PC_IDX] + DATA_W'(1);
    if (ext_we && (32'(wr_addr) < NUM_REGS)) regs_d[wr_addr] = wr_data;
    if (seq_ld) regs_d[idx] = seq_data_in;
  end

`ifdef RF_BYPASS_EN
  assign view = regs_d;
`else
  assign view = regs_q;
`endif

  always_comb begin
    rd_data1 = '0;
    rd_data2 = '0;
    if (32'(rd_addr1) < NUM_REGS) rd_data1 = view[rd_addr1];
    if (32'(rd_addr2) < NUM_REGS) rd_data2 = view[rd_addr2];
  end

  assign pc_out       = regs_q[PC_IDX];
  assign seq_busy     = run;
  assign seq_valid    = run;
  assign seq_addr     = run ? idx : '0;
  assign seq_data_out = (run && !mode_q) ? view[idx] : '0;
  assign seq_done     = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    mask_d  = mask_q;
    unique case (state_q)
      IDLE: begin
        if (seq_start) begin
          mode_d  = seq_mode;
          mask_d  = seq_mask;
          state_d = (|seq_mask) ? RUN : DONE;
        end
      end
      RUN: begin
        mask_d = mask_q & (mask_q - NUM_REGS'(1));
        if (mask_d == '0) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      mask_q  <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      mask_q  <= mask_d;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

endmodule
